// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
//
// Forwarding and load-use hazard unit for the in-order RV32I pipeline.
// Keeps a shift-register scoreboard of the destination registers held by
// the in-flight instructions in stages 1..NUM_STAGES after decode
// (1 = EX, 2 = MEM, 3 = WB). From it, for every decode source operand,
// the unit selects the youngest in-flight producer. It raises a stall when
// that producer's result is not yet available, and it counts the bubbles
// inserted by those stalls.
//
// Ports
//   clk         clock
//   rst         synchronous active-high reset
//   id_valid    decode slot holds a real instruction
//   id_rs       source indices, source i at [5i+4:5i]
//   id_rs_used  source i is actually read
//   id_rd       destination index of the decode instruction
//   id_rd_we    decode instruction writes rd
//   id_is_load  decode instruction is a load
//   advance     pipeline moves this cycle
//   flush       kill the decode slot and stage 1 (redirect)
//   mem_resp    load data valid at LOAD_STAGE this cycle
//   fwd_sel     per-source select: 0 = regfile, s = forward from stage s
//   stall       hold decode/fetch and insert a bubble
//   bubble_cnt  saturating count of inserted bubbles
// ---------------------------------------------------------------------------
module fwd_hazard_unit #(
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned LOAD_STAGE = 2,
    parameter int unsigned CNT_W      = 32,
    localparam int unsigned SW        = $clog2(NUM_STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [NUM_SRC*5-1:0]  id_rs,
    input  logic [NUM_SRC-1:0]    id_rs_used,
    input  logic [4:0]            id_rd,
    input  logic                  id_rd_we,
    input  logic                  id_is_load,
    input  logic                  advance,
    input  logic                  flush,
    input  logic                  mem_resp,
    output logic [NUM_SRC*SW-1:0] fwd_sel,
    output logic                  stall,
    output logic [CNT_W-1:0]      bubble_cnt
);

    // Array index k holds pipeline stage k+1.
    localparam int unsigned LI = LOAD_STAGE - 1;

    logic [NUM_STAGES-1:0]      valid_q, valid_d;
    logic [NUM_STAGES-1:0][4:0] rd_q, rd_d;
    logic [NUM_STAGES-1:0]      load_q, load_d;
    logic [NUM_STAGES-1:0]      ready_q, ready_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;

    logic [NUM_STAGES-1:0]      live;
    logic [NUM_STAGES-1:0]      rdy_eff;
    logic                       ld_resp;
    logic [NUM_SRC-1:0]         hit;
    logic [NUM_SRC-1:0]         src_wait;
    logic [NUM_SRC*SW-1:0]      sel;
    logic                       stall_w;
    logic                       take;
    logic                       new_valid;

    // A load sitting at LOAD_STAGE whose data arrives this cycle.
    assign ld_resp = valid_q[LI] & load_q[LI] & mem_resp;

    // Liveness and effective readiness per stage. The response at
    // LOAD_STAGE is bypassed so a dependent instruction can take the
    // forwarded data in the very cycle it arrives.
    always_comb begin
        live    = '0;
        rdy_eff = '0;
        for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            live[k] = valid_q[k] & (rd_q[k] != 5'd0);
            if (k > LI) begin
                rdy_eff[k] = 1'b1;
            end else if (k == LI) begin
                rdy_eff[k] = ready_q[k] | ld_resp;
            end else begin
                rdy_eff[k] = ready_q[k];
            end
        end
    end

    // Youngest live match per source: scanning from stage 1 upward and
    // keeping only the first hit gives the smallest stage number.
    always_comb begin
        sel      = '0;
        hit      = '0;
        src_wait = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (id_rs_used[i] && (id_rs[5*i +: 5] != 5'd0)) begin
                for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                    if (!hit[i] && live[k] && (rd_q[k] == id_rs[5*i +: 5])) begin
                        hit[i]          = 1'b1;
                        sel[SW*i +: SW] = SW'(k + 1);
                        src_wait[i]     = ~rdy_eff[k];
                    end
                end
            end
        end
    end

    assign stall_w   = id_valid & ~flush & (|src_wait);
    assign take      = id_valid & ~flush & ~stall_w;
    assign new_valid = take & id_rd_we & (id_rd != 5'd0);

    // Scoreboard next state.
    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        load_d  = load_q;
        ready_d = ready_q;

        if (advance) begin
            for (int unsigned k = 1; k < NUM_STAGES; k++) begin
                valid_d[k] = valid_q[k-1];
                rd_d[k]    = rd_q[k-1];
                load_d[k]  = load_q[k-1];
                ready_d[k] = ready_q[k-1];
                // A response arriving as the load leaves LOAD_STAGE
                // travels with the entry.
                if (k - 1 == LI) begin
                    ready_d[k] = ready_q[k-1] | ld_resp;
                end
            end
            // The redirect kills the stage 1 occupant before it moves on.
            if (flush) begin
                valid_d[1] = 1'b0;
                load_d[1]  = 1'b0;
                ready_d[1] = 1'b0;
            end
            valid_d[0] = new_valid;
            rd_d[0]    = take ? id_rd : 5'd0;
            load_d[0]  = new_valid & id_is_load;
            ready_d[0] = new_valid & ~id_is_load;
        end else begin
            ready_d[LI] = ready_q[LI] | ld_resp;
            if (flush) begin
                valid_d[0] = 1'b0;
                load_d[0]  = 1'b0;
                ready_d[0] = 1'b0;
            end
        end
    end

    // Saturating bubble counter.
    always_comb begin
        cnt_d = cnt_q;
        if (advance && stall_w && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            rd_q    <= '0;
            load_q  <= '0;
            ready_q <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
            load_q  <= load_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fwd_sel    = sel;
    assign stall      = stall_w;
    assign bubble_cnt = cnt_q;

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit for the in-order RV32I pipeline; the successor to the fixed two-source, fixed-stage rs1/rs2 forwarding selects.
- Tracks destination registers of in-flight instructions in a shift-register scoreboard (stages 1..NUM_STAGES after decode).
- Produces a per-source forward select, a load-use stall, and a saturating bubble counter.

Parameters:
NUM_SRC, 2, number of decode-stage source operands checked
NUM_STAGES, 3, tracked stages after decode (1 = EX, 2 = MEM, 3 = WB)
LOAD_STAGE, 2, stage where load data becomes valid on mem_resp; 1 < LOAD_STAGE <= NUM_STAGES
CNT_W, 32, width of bubble counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_valid  in  1  decode slot holds a real instruction
id_rs  in  NUM_SRC*5  source register indices; source i at bits [5i+4:5i]
id_rs_used  in  NUM_SRC  source i is actually read
id_rd  in  5  destination index
id_rd_we  in  1  instruction writes rd
id_is_load  in  1  instruction is a load
advance  in  1  pipeline moves this cycle (0 during cache stalls)
flush  in  1  kill decode slot and stage 1 (branch/jump redirect)
mem_resp  in  1  load data valid at LOAD_STAGE this cycle
fwd_sel  out  NUM_SRC*SW  SW = $clog2(NUM_STAGES+1); 0 = regfile, s = forward from stage s
stall  out  1  hold decode/fetch, insert bubble
bubble_cnt  out  CNT_W  cycles a bubble was inserted

Behaviour:
- Entry per stage: valid, rd, is_load, ready. The entry is "live" iff valid & rd != 0 (rd_we=0 or rd=x0 entries are stored with valid=0).
- Reset: all valid=0, ready=0, bubble_cnt=0. Hence stall=0 and all fwd_sel=0 in the cycle after reset. Reset mid-operation discards all entries with no retirement side effects.
- fwd_sel[i] (combinational): 0 if !id_rs_used[i] or id_rs[i]==0; otherwise the smallest s with a live entry and rd==id_rs[i] (youngest wins); 0 if there is no match.
- stall (combinational) = id_valid & !flush & (some used source's youngest matching entry has ready==0).
- Ready rules:
  - Non-load enters stage 1 with ready=1.
  - Load enters with ready=0 and sets ready=1 at stage LOAD_STAGE when mem_resp=1 (sticky).
  - Entries in stages > LOAD_STAGE are always treated as ready.
- Sequential update, priority order:
  1. rst.
  2. advance=0: hold all entries; only a load at LOAD_STAGE may set ready. flush while advance=0 clears stage 1 only.
  3. advance=1: stage s+1 <= stage s for s >= 1; the stage NUM_STAGES entry retires. Stage 1 <=
     - bubble if flush, else
     - bubble if stall, else
     - the decode instruction if id_valid, else bubble.
- A ready set by mem_resp in the same cycle as the load shifts out of LOAD_STAGE is carried with the entry.
- bubble_cnt increments when advance & stall; it saturates at all-ones (no wrap).
- Load at stage 1 followed by a dependent instruction: stall=1 for exactly one advance cycle when mem_resp arrives in the first LOAD_STAGE cycle. After that, fwd_sel=LOAD_STAGE.

Test Plan:
- Reset, then id_rs={x5,x6} used with no entries -> fwd_sel={0,0}, stall=0, bubble_cnt=0.
- ADD x5 then SUB x7,x5,x5 back-to-back with advance=1 -> at decode of SUB, fwd_sel={1,1}, stall=0. One cycle later an instruction reading x5 -> sel=2.
- ADDI x5 then ADDI x5 then read x5 -> sel=1 (youngest wins). Writes to x0 or rd_we=0 -> sel=0.
- LW x8 then ADD x9,x8,x1 -> stall=1 for one cycle, bubble_cnt=1. Next cycle (load at stage 2, mem_resp=1) -> stall=0, fwd_sel[0]=2.
- LW x8 at stage 2, advance=0, mem_resp=0 for 4 cycles -> state held, stall=1, bubble_cnt unchanged. Then mem_resp=1 -> stall=0.
- flush=1 with live entry in stage 1 and advance=1 -> that entry does not appear at stage 2 and the decode instruction is not entered. Preload bubble_cnt to all-ones, force a bubble -> stays all-ones. rst asserted mid-stall -> stall=0 next cycle.
